// File: rtl/sum_accumulator.sv
// sum_accumulator
//
// Accumulates a burst of ripple-carry adder results into a wide running
// total. Each accepted beat contributes the unsigned value {cout, s}. After
// the programmed number of beats, the total, a sticky overflow flag and the
// beat count are presented on a valid/ready output.
//
// Build option:
//   SUM_ACC_SATURATE_EN -- when defined, an overflow in the ACC state clamps
//                          acc to all-ones for the rest of the burst.
//                          When undefined, acc wraps modulo 2^ACC_W.
//                          ovf is set in both builds.
//
// Parameters:
//   width : sum width of the feeding adder (s is width bits, plus cout)
//   ACC_W : accumulator width, must be >= width+1
//   CNT_W : beat-counter width; the longest burst is 2^CNT_W-1 beats
//
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : s/cout/len are valid
//   in_ready  : beat accepted on in_valid & in_ready (state decode)
//   s, cout   : adder result; cout is the MSB of the beat value
//   len       : burst length, sampled on the first beat; 0 counts as 1
//   out_valid : total available
//   out_ready : downstream accepts the total
//   acc       : accumulated total
//   ovf       : sticky overflow for the current burst
//   beats     : beats accepted in the current burst
module sum_accumulator #(
  parameter int width = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] s,
  input  logic             cout,
  input  logic [CNT_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic [CNT_W-1:0] beats
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } acc_res_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W-1:0] beat_v;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] beats_inc;
  logic             hs;
  acc_res_t         add_res;

  // One extra bit catches the carry out of the accumulator. The overflow
  // flag is sticky across the burst; in the saturating build a set flag
  // pins the total at all-ones so later beats cannot bring it back down.
  function automatic acc_res_t acc_add(input logic [ACC_W-1:0] a,
                                       input logic [ACC_W-1:0] b,
                                       input logic             ovf_in);
    logic [ACC_W:0] sum;
    acc_res_t       res;
    sum     = {1'b0, a} + {1'b0, b};
    res.ovf = ovf_in | sum[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
    res.acc = res.ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    res.acc = sum[ACC_W-1:0];
`endif
    return res;
  endfunction

  // in_ready is a pure state decode so there is no input-to-output path.
  assign in_ready  = (state_q != S_DONE);
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign ovf       = ovf_q;
  assign beats     = beats_q;

  assign hs        = in_valid & in_ready;
  assign len_eff   = (len == '0) ? CNT_W'(1) : len;
  assign beats_inc = beats_q + CNT_W'(1);

  always_comb begin
    beat_v            = '0;
    beat_v[width:0]   = {cout, s};
  end

  assign add_res = acc_add(acc_q, beat_v, ovf_q);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    beats_d     = beats_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          acc_d   = beat_v;
          beats_d = CNT_W'(1);
          ovf_d   = 1'b0;
          len_d   = len_eff;
          if (len_eff == CNT_W'(1)) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d     = S_ACC;
          end
        end
      end

      S_ACC: begin
        if (hs) begin
          acc_d   = add_res.acc;
          ovf_d   = add_res.ovf;
          beats_d = beats_inc;
          if (beats_inc == len_q) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        // Results stay put after the handoff until the next first beat.
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      beats_q     <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      beats_q     <= beats_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator. A default-sized instance and a 9-bit
// accumulator instance share all inputs; the narrow one exercises overflow.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  s;
  logic        cout;
  logic [3:0]  len;
  logic        out_ready;

  logic        in_ready, out_valid, ovf;
  logic [15:0] acc;
  logic [3:0]  beats;

  logic        in_ready_n, out_valid_n, ovf_n;
  logic [8:0]  acc_n;
  logic [3:0]  beats_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.width(8), .ACC_W(16), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .cout(cout), .len(len), .out_valid(out_valid),
    .out_ready(out_ready), .acc(acc), .ovf(ovf), .beats(beats)
  );

  sum_accumulator #(.width(8), .ACC_W(9), .CNT_W(4)) u_narrow (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .s(s), .cout(cout), .len(len), .out_valid(out_valid_n),
    .out_ready(out_ready), .acc(acc_n), .ovf(ovf_n), .beats(beats_n)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic release_total();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; s = 8'h00; cout = 1'b0; len = 4'd0;
    out_ready = 1'b0;

    // Reset, with a beat presented during reset that must be ignored.
    tick();
    in_valid = 1'b1; s = 8'h55; len = 4'd1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc",       acc,       0);
    check("rst_ovf",       ovf,       0);
    check("rst_beats",     beats,     0);
    tick();
    check("rst_beat_ignored", out_valid, 0);

    // Single beat: {1, 0xFF} = 0x1FF.
    in_valid = 1'b1; len = 4'd1; s = 8'hFF; cout = 1'b1;
    tick();
    in_valid = 1'b0; cout = 1'b0;
    check("single_out_valid", out_valid, 1);
    check("single_in_ready",  in_ready,  0);
    check("single_acc",       acc,       16'h01FF);
    check("single_beats",     beats,     1);
    check("single_ovf",       ovf,       0);
    release_total();
    check("single_idle_valid", out_valid, 0);
    check("single_idle_ready", in_ready,  1);
    check("single_idle_hold",  acc,       16'h01FF);

    // Four beats 3+5+7+9 with a gap; len rewritten to 2 mid-burst.
    in_valid = 1'b1; len = 4'd4; s = 8'd3;
    tick();
    len = 4'd2; s = 8'd5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("gap_out_valid", out_valid, 0);
    check("gap_in_ready",  in_ready,  1);
    check("gap_acc",       acc,       8);
    check("gap_beats",     beats,     2);
    in_valid = 1'b1; s = 8'd7;
    tick();
    s = 8'd9;
    tick();
    in_valid = 1'b0;
    check("four_out_valid", out_valid, 1);
    check("four_acc",       acc,       24);
    check("four_beats",     beats,     4);

    // Backpressure: hold in DONE for 5 cycles with in_valid high.
    in_valid = 1'b1; s = 8'h11; len = 4'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready",  in_ready,  0);
      check("bp_out_valid", out_valid, 1);
      check("bp_acc",       acc,       24);
      check("bp_beats",     beats,     4);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_done_out_valid", out_valid, 0);
    check("bp_done_no_accept", acc,       24);
    check("bp_idle_ready",     in_ready,  1);
    tick();
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_acc",   acc,       16'h0011);
    check("bp_next_beats", beats,     1);
    release_total();

    // Overflow: three beats of 0x1FF. 3*0x1FF = 0x5FD; in 9 bits the
    // wrapping build keeps 0x1FD, the saturating build clamps to 0x1FF.
    in_valid = 1'b1; len = 4'd3; s = 8'hFF; cout = 1'b1;
    tick();
    tick();
    tick();
    in_valid = 1'b0; cout = 1'b0;
    check("ovf_valid_n", out_valid_n, 1);
    check("ovf_beats_n", beats_n,     3);
    check("ovf_flag_n",  ovf_n,       1);
`ifdef SUM_ACC_SATURATE_EN
    check("ovf_acc_n",   acc_n,       9'h1FF);
`else
    check("ovf_acc_n",   acc_n,       9'h1FD);
`endif
    check("ovf_acc_wide",  acc, 16'h05FD);
    check("ovf_flag_wide", ovf, 0);
    release_total();

    // len = 0 behaves as a single beat; overflow flag cleared by new burst.
    in_valid = 1'b1; len = 4'd0; s = 8'h10;
    tick();
    in_valid = 1'b0;
    check("len0_valid",  out_valid, 1);
    check("len0_acc",    acc,       16'h0010);
    check("len0_beats",  beats,     1);
    check("len0_ovf_n",  ovf_n,     0);
    check("len0_acc_n",  acc_n,     9'h010);
    release_total();

    // Mid-burst reset after 2 of 5 beats, beat offered during reset.
    in_valid = 1'b1; len = 4'd5; s = 8'd7;
    tick();
    tick();
    rst = 1'b1; s = 8'h40;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("mrst_acc",       acc,       0);
    check("mrst_ovf",       ovf,       0);
    check("mrst_beats",     beats,     0);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready",  in_ready,  1);
    in_valid = 1'b1; len = 4'd2; s = 8'd1;
    tick();
    check("fresh_mid_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("fresh_valid", out_valid, 1);
    check("fresh_acc",   acc,       2);
    check("fresh_beats", beats,     2);
    release_total();
    check("fresh_released", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
